gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Synthesizable exhaustive stimulus/response engine for small combinational gates such as nand2.
- On `start`, drives every input vector 0 .. 2**N_IN-1 onto the DUT and waits a settle interval.
- It then samples the DUT output and compares it against a parameterised truth table.
- Reports a per-vector mismatch mask and a pass flag; used as on-chip self-test next to primitive gate instances.

Parameters:
- N_IN, 2, number of DUT inputs; sweep length V = 2**N_IN vectors.
- TRUTH, 4'b0111, expected output per vector (width V); TRUTH[v] is the expected dut_out for dut_in==v. Default is NAND2.
- SETTLE, 2, wait cycles per vector before sampling; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; accepted only in IDLE.
- dut_in  out  N_IN  vector driven to the DUT; dut_in[N_IN-1] is the MSB gate input.
- dut_out  in  1  DUT response.
- busy  out  1  high from the cycle after acceptance until the DONE state is left.
- done  out  1  one-cycle pulse when results are valid.
- pass  out  1  1 when fail_mask==0; valid from done, held until next acceptance.
- fail_mask  out  V  bit v set if dut_out != TRUTH[v].

Behaviour:
- Reset values (async, rst_n low): state=IDLE, dut_in=0, busy=0, done=0, pass=0, fail_mask=0, settle counter=0, vector index=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: if start==1, accept the request:
  - fail_mask<=0, pass<=0, vec<=0, dut_in<=0, cnt<=SETTLE.
  - Next state is SETTLE, or SAMPLE if SETTLE==0.
- SETTLE: cnt decrements each cycle; when cnt==1, go to SAMPLE. dut_in is held.
- SAMPLE: fail_mask[vec] <= (dut_out != TRUTH[vec]).
  - If vec==V-1, go to DONE.
  - Otherwise vec<=vec+1, dut_in<=vec+1, cnt<=SETTLE, and go to SETTLE (or stay in SAMPLE if SETTLE==0).
- DONE: done=1 for exactly this cycle; pass <= ~|fail_mask (mask is final since the SAMPLE write has landed). Next state is IDLE; dut_in returns to 0.
- Latency: each vector occupies exactly SETTLE+1 cycles. With acceptance at edge E0, done is high in cycle V*(SETTLE+1) after E0.
- busy = (state != IDLE), registered via the state.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new sweep is accepted on the first IDLE cycle after DONE, i.e. back-to-back sweeps with one IDLE cycle between.
- Vector index wrap: never wraps. vec is N_IN+1 bits wide internally, and the terminal test is vec==V-1.
- Reset mid-sweep: all outputs return immediately to reset values; the partial mask is discarded; no done pulse.
- dut_out is assumed combinationally stable by the sample cycle. Only the sampled value counts; glitches during SETTLE are ignored.

Optional Feature:
- Macro: GATE_SWEEP_FIRST_FAIL_EN.
- Enabled:
  - Extra outputs first_fail_vld (1 bit) and first_fail_idx (N_IN bits).
  - On the first mismatching SAMPLE of a sweep, these capture vec and set vld. They are cleared on acceptance and at reset.
  - Later mismatches do not overwrite them.
- Disabled: ports absent; no capture logic.

Decomposition:
- Package gate_check_pkg:
  - State enum (IDLE, SETTLE, SAMPLE, DONE) as a 2-bit typedef.
  - Constants NAND2_TT=4'b0111, AND2_TT=4'b1000, OR2_TT=4'b1110, XOR2_TT=4'b0110, SETTLE_MAX=15.
- One sub-module, settle_timer: a loadable down-counter with a load, a 4-bit value, and an expire pulse.
- The FSM, vector counter and mask stay in the top module.

Test Plan:
- Correct NAND2 DUT, SETTLE=2, start pulse -> dut_in steps 00,01,10,11, each held 3 cycles; done in cycle 12 after acceptance; fail_mask=4'b0000; pass=1.
- DUT is an AND2, TRUTH=NAND2_TT -> fail_mask=4'b1111, pass=0.
- DUT output stuck-at-1 -> fail_mask=4'b1000, pass=0.
  - With GATE_SWEEP_FIRST_FAIL_EN: first_fail_vld=1, first_fail_idx=2'b11.
- Extra start pulses at cycles 3 and 7 of a sweep -> ignored; exactly one done; no second sweep. Start held high -> second sweep accepted one cycle after DONE.
- rst_n low at cycle 5 of a sweep, released 2 cycles later -> busy=0, dut_in=0, fail_mask=0 immediately; no done. A subsequent start gives a normal full sweep.
- SETTLE=0 with a correct NAND2 DUT -> one cycle per vector; done in cycle 4; pass=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types and truth-table constants for the gate sweep checker
package gate_check_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] NAND2_TT   = 4'b0111;
    localparam logic [3:0] AND2_TT    = 4'b1000;
    localparam logic [3:0] OR2_TT     = 4'b1110;
    localparam logic [3:0] XOR2_TT    = 4'b0110;
    localparam int         SETTLE_MAX = 15;

endpackage

// File: rtl/gate_sweep_checker_settle_timer.sv
// rtl/gate_sweep_checker_settle_timer.sv - loadable 4-bit down-counter with expire pulse
// Ports: clk, rst_n (async active-low), load/value (reload the count),
//        expire (high while the count equals 1, i.e. in the last wait cycle).
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] value,
    output logic       expire
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign expire = (cnt == 4'd1);

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive input sweep and truth-table check of a small gate
// Ports: clk, rst_n (async active-low), start (sweep request, taken in IDLE),
//        dut_in (vector to the gate), dut_out (gate response), busy, done (1-cycle pulse),
//        pass (mask clear), fail_mask (per-vector mismatch bits).
// Optional GATE_SWEEP_FIRST_FAIL_EN adds first_fail_vld / first_fail_idx capturing the
// first mismatching vector of a sweep.
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = NAND2_TT,
    parameter int                      SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    output logic                   first_fail_vld,
    output logic [N_IN-1:0]        first_fail_idx,
`endif
    output logic [(1<<N_IN)-1:0]   fail_mask
);

    localparam int V = 1 << N_IN;

    state_t            state;
    state_t            state_nxt;
    logic [N_IN:0]     vec;
    logic              accept;
    logic              last;
    logic              mismatch;
    logic              timer_load;
    logic              timer_expire;
    logic [V-1:0]      mask_upd;

    assign accept   = (state == S_IDLE) && start;
    assign last     = (vec == (N_IN+1)'(V - 1));
    assign mismatch = (dut_out != TRUTH[vec[N_IN-1:0]]);

    // Reload on acceptance and on every non-final sample so each vector gets a full wait.
    assign timer_load = accept || ((state == S_SAMPLE) && !last);

    settle_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .value  (4'(SETTLE)),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (timer_expire) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (last) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Mask as it will stand after the current sample lands.
    always_comb begin
        mask_upd = fail_mask;
        mask_upd[vec[N_IN-1:0]] = mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            dut_in    <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vec       <= '0;
                        dut_in    <= '0;
                        fail_mask <= '0;
                        pass      <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    fail_mask <= mask_upd;
                    if (last) begin
                        // Pass is settled on entry to DONE so it is already valid with the pulse.
                        pass <= ~|mask_upd;
                    end else begin
                        vec    <= vec + 1'b1;
                        dut_in <= dut_in + 1'b1;
                    end
                end
                S_DONE: begin
                    pass   <= ~|fail_mask;
                    dut_in <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SWEEP_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (accept) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if ((state == S_SAMPLE) && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= vec[N_IN-1:0];
        end
    end
`endif

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - directed self-checking bench for gate_sweep_checker
module tb_gate_sweep_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s0, s1;
    int         mode;
    logic [1:0] in0, in1;
    logic       o0, o1;
    logic       b0, b1, d0, d1, p0, p1;
    logic [3:0] m0, m1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic       ffv0, ffv1;
    logic [1:0] ffi0, ffi1;
`endif

    int total = 0;
    int bad   = 0;

    // mode 0: NAND2, 1: AND2, 2: stuck-at-1
    function automatic logic gate(input int m, input logic [1:0] v);
        case (m)
            0:       gate = ~(v[1] & v[0]);
            1:       gate = v[1] & v[0];
            default: gate = 1'b1;
        endcase
    endfunction

    assign o0 = gate(mode, in0);
    assign o1 = gate(mode, in1);

    gate_sweep_checker #(.N_IN(2), .TRUTH(NAND2_TT), .SETTLE(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(s0), .dut_in(in0), .dut_out(o0),
        .busy(b0), .done(d0), .pass(p0),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        .first_fail_vld(ffv0), .first_fail_idx(ffi0),
`endif
        .fail_mask(m0)
    );

    gate_sweep_checker #(.N_IN(2), .TRUTH(NAND2_TT), .SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .dut_in(in1), .dut_out(o1),
        .busy(b1), .done(d1), .pass(p1),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        .first_fail_vld(ffv1), .first_fail_idx(ffi1),
`endif
        .fail_mask(m1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full sweep on instance sel (0: SETTLE=2, 1: SETTLE=0); cycle k counts from the accept edge.
    task automatic sweep(input int sel, input logic [3:0] m_exp, input logic p_exp);
        int per;
        per = (sel == 1) ? 1 : 3;
        if (sel == 1) s1 = 1'b1; else s0 = 1'b1;
        step();
        s0 = 1'b0;
        s1 = 1'b0;
        for (int k = 0; k < 4 * per; k++) begin
            chk("busy_in_sweep", (sel == 1) ? b1 : b0, 1);
            chk("dut_in_step",   (sel == 1) ? in1 : in0, k / per);
            chk("done_early",    (sel == 1) ? d1 : d0, 0);
            step();
        end
        chk("done_pulse", (sel == 1) ? d1 : d0, 1);
        chk("fail_mask",  (sel == 1) ? m1 : m0, m_exp);
        step();
        chk("done_drop", (sel == 1) ? d1 : d0, 0);
        chk("busy_end",  (sel == 1) ? b1 : b0, 0);
        chk("dut_in_end", (sel == 1) ? in1 : in0, 0);
        chk("pass",      (sel == 1) ? p1 : p0, p_exp);
    endtask

    initial begin
        rst_n = 1'b0;
        s0    = 1'b0;
        s1    = 1'b0;
        mode  = 0;
        step();
        step();
        chk("rst_busy", b0, 0);
        chk("rst_done", d0, 0);
        chk("rst_pass", p0, 0);
        chk("rst_mask", m0, 0);
        chk("rst_dut_in", in0, 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("rst_ff_vld", ffv0, 0);
`endif
        rst_n = 1'b1;
        step();
        chk("idle_busy", b0, 0);

        // Correct NAND2
        mode = 0;
        sweep(0, 4'b0000, 1'b1);

        // AND2 against a NAND2 table: every vector wrong
        mode = 1;
        sweep(0, 4'b1111, 1'b0);

        // Stuck-at-1: only vector 3 wrong
        mode = 2;
        sweep(0, 4'b1000, 1'b0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("ff_vld", ffv0, 1);
        chk("ff_idx", ffi0, 3);
`endif

        // Extra start pulses during the sweep and in DONE are ignored
        mode = 0;
        s0 = 1'b1;
        step();
        s0 = 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("ff_clear_on_accept", ffv0, 0);
`endif
        for (int k = 0; k < 12; k++) begin
            s0 = (k == 3 || k == 7);
            chk("ign_done_early", d0, 0);
            step();
        end
        s0 = 1'b1;
        chk("ign_done", d0, 1);
        step();
        s0 = 1'b0;
        chk("ign_busy_after", b0, 0);
        chk("ign_pass", p0, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ign_no_second", b0 | d0, 0);
        end

        // Start held high: back-to-back sweeps with one IDLE cycle between
        s0 = 1'b1;
        step();
        for (int k = 0; k < 12; k++) step();
        chk("held_done1", d0, 1);
        step();
        chk("held_idle_gap", b0, 0);
        chk("held_pass1", p0, 1);
        step();
        chk("held_busy2", b0, 1);
        chk("held_dut_in2", in0, 0);
        s0 = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("held_done2", d0, 1);
        step();
        chk("held_busy_end", b0, 0);

        // Reset mid-sweep discards the partial mask
        mode = 1;
        s0 = 1'b1;
        step();
        s0 = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("pre_rst_mask", m0, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", b0, 0);
        chk("mid_rst_dut_in", in0, 0);
        chk("mid_rst_mask", m0, 0);
        chk("mid_rst_done", d0, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_quiet", b0 | d0, 0);
        end
        mode = 0;
        sweep(0, 4'b0000, 1'b1);

        // SETTLE=0: one cycle per vector
        sweep(1, 4'b0000, 1'b1);
        mode = 2;
        sweep(1, 4'b1000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
